sprite_datapath: RTL and testbench

// Datapath directly downstream of the movement FSM. Consumes its 4-bit STATE and PorB,

---
 rtl/sprite_datapath.sv | 157 +++++++++++++++
 tb/tb_sprite_datapath.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_datapath.sv
// Sprite datapath: holds player/bird positions, applies one-step moves on state entry,
// and sweeps a sprite box into the VGA adapter (erase in CLEAR, paint in DRAW).
module sprite_datapath #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned SPR      = 4,
    parameter int unsigned STEP     = 1,
    parameter int unsigned P_X0     = 78,
    parameter int unsigned P_Y0     = 58,
    parameter int unsigned B_X0     = 10,
    parameter int unsigned B_Y0     = 100,
    parameter logic [2:0]  BG_COL   = 3'b011,
    parameter logic [2:0]  P_COL    = 3'b111,
    parameter logic [2:0]  B_COL    = 3'b100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] state,
    input  logic       porb,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done_drawing,
    output logic [7:0] player_x,
    output logic [6:0] player_y,
    output logic [7:0] bird_x,
    output logic [6:0] bird_y
);

    localparam int unsigned XW   = 8;
    localparam int unsigned YW   = 7;
    localparam int unsigned XW1  = XW + 1;
    localparam int unsigned YW1  = YW + 1;
    localparam int unsigned CW   = $clog2(SPR);
    localparam int unsigned NPIX = SPR * SPR;
    localparam int unsigned IW   = $clog2(NPIX) + 1;

    localparam logic [3:0] ST_CLEAR = 4'd1;
    localparam logic [3:0] ST_RIGHT = 4'd2;
    localparam logic [3:0] ST_LEFT  = 4'd3;
    localparam logic [3:0] ST_DRAW  = 4'd5;
    localparam logic [3:0] ST_DOWN  = 4'd6;
    localparam logic [3:0] ST_UP    = 4'd7;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} sweep_t;

    sweep_t          sw_fsm;
    logic [3:0]      prev_state;
    logic [3:0]      sweep_state;
    logic            obj;
    logic            done_reg;
    logic [IW-1:0]   idx;
    logic [XW-1:0]   base_x;
    logic [YW-1:0]   base_y;

    logic            entry;
    logic            sweep_start;
    logic [XW-1:0]   sel_x;
    logic [YW-1:0]   sel_y;
    logic [XW:0]     x_up;
    logic [YW:0]     y_up;
    logic [XW-1:0]   x_right;
    logic [XW-1:0]   x_left;
    logic [YW-1:0]   y_down;
    logic [YW-1:0]   y_upmove;
    logic [CW-1:0]   cx;
    logic [CW-1:0]   cy;

    assign entry        = (state != prev_state);
    assign sweep_start  = entry && ((state == ST_CLEAR) || (state == ST_DRAW));
    assign done_drawing = done_reg && (state == sweep_state);
    assign cx           = idx[CW-1:0];
    assign cy           = idx[2*CW-1:CW];

    // Clamped one-step candidates for the selected object, computed one bit wider
    always_comb begin
        sel_x    = porb ? bird_x : player_x;
        sel_y    = porb ? bird_y : player_y;
        x_up     = {1'b0, sel_x} + XW1'(STEP);
        y_up     = {1'b0, sel_y} + YW1'(STEP);
        x_right  = (x_up > XW1'(SCREEN_W - SPR)) ? XW'(SCREEN_W - SPR) : x_up[XW-1:0];
        y_down   = (y_up > YW1'(SCREEN_H - SPR)) ? YW'(SCREEN_H - SPR) : y_up[YW-1:0];
        x_left   = ({1'b0, sel_x} < XW1'(STEP)) ? '0 : XW'({1'b0, sel_x} - XW1'(STEP));
        y_upmove = ({1'b0, sel_y} < YW1'(STEP)) ? '0 : YW'({1'b0, sel_y} - YW1'(STEP));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_state <= 4'hF;
        else          prev_state <= state;
    end

    // Position update on move-state entry only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            player_x <= XW'(P_X0);
            player_y <= YW'(P_Y0);
            bird_x   <= XW'(B_X0);
            bird_y   <= YW'(B_Y0);
        end else if (entry) begin
            case (state)
                ST_RIGHT: if (porb) bird_x <= x_right;  else player_x <= x_right;
                ST_LEFT:  if (porb) bird_x <= x_left;   else player_x <= x_left;
                ST_DOWN:  if (porb) bird_y <= y_down;   else player_y <= y_down;
                ST_UP:    if (porb) bird_y <= y_upmove; else player_y <= y_upmove;
                default: ;
            endcase
        end
    end

    // Sweep FSM: pixel 0 is emitted on the entry edge so it appears the cycle after entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_fsm      <= S_IDLE;
            sweep_state <= 4'h0;
            obj         <= 1'b0;
            done_reg    <= 1'b0;
            idx         <= '0;
            base_x      <= '0;
            base_y      <= '0;
            plot        <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            colour      <= '0;
        end else if (sweep_start) begin
            sw_fsm      <= S_SWEEP;
            sweep_state <= state;
            obj         <= porb;
            done_reg    <= 1'b0;
            idx         <= IW'(1);
            base_x      <= sel_x;
            base_y      <= sel_y;
            plot        <= 1'b1;
            x_out       <= sel_x;
            y_out       <= sel_y;
            colour      <= (state == ST_CLEAR) ? BG_COL : (porb ? B_COL : P_COL);
        end else begin
            case (sw_fsm)
                S_SWEEP: begin
                    if (idx == IW'(NPIX)) begin
                        plot     <= 1'b0;
                        done_reg <= 1'b1;
                        sw_fsm   <= S_DONE;
                    end else begin
                        plot   <= 1'b1;
                        x_out  <= base_x + XW'(cx);
                        y_out  <= base_y + YW'(cy);
                        colour <= (sweep_state == ST_CLEAR) ? BG_COL : (obj ? B_COL : P_COL);
                        idx    <= idx + IW'(1);
                    end
                end
                default: plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_datapath.sv
// Self-checking bench for sprite_datapath against a position/sweep reference model.
module tb_sprite_datapath;

    localparam logic [3:0] CLR = 4'd1, RGT = 4'd2, LFT = 4'd3, DRW = 4'd5, DWN = 4'd6, UPS = 4'd7;
    localparam int XMAX = 156, YMAX = 116;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] state;
    logic       porb;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       done_drawing;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic [7:0] bird_x;
    logic [6:0] bird_y;

    int n_checks = 0;
    int n_fail   = 0;
    int m_px, m_py, m_bx, m_by, m_prev;

    sprite_datapath dut (
        .clk(clk), .reset_n(reset_n), .state(state), .porb(porb),
        .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
        .done_drawing(done_drawing), .player_x(player_x), .player_y(player_y),
        .bird_x(bird_x), .bird_y(bird_y)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_px = 78; m_py = 58; m_bx = 10; m_by = 100; m_prev = 15;
    endtask

    // Drive inputs and advance the model: moves act only when the state value changes
    task automatic set_inputs(input logic [3:0] st, input logic pb);
        int x, y;
        state = st;
        porb  = pb;
        if (int'(st) != m_prev) begin
            x = pb ? m_bx : m_px;
            y = pb ? m_by : m_py;
            case (st)
                RGT: x = (x + 1 > XMAX) ? XMAX : x + 1;
                LFT: x = (x < 1) ? 0 : x - 1;
                DWN: y = (y + 1 > YMAX) ? YMAX : y + 1;
                UPS: y = (y < 1) ? 0 : y - 1;
                default: ;
            endcase
            if (pb) begin m_bx = x; m_by = y; end
            else    begin m_px = x; m_py = y; end
        end
        m_prev = int'(st);
    endtask

    task automatic check_positions(input string tag);
        n_checks++;
        if (player_x !== 8'(m_px) || player_y !== 7'(m_py) || bird_x !== 8'(m_bx) || bird_y !== 7'(m_by)) begin
            n_fail++;
            $display("FAIL %s positions: got p=(%0d,%0d) b=(%0d,%0d) want p=(%0d,%0d) b=(%0d,%0d)",
                     tag, player_x, player_y, bird_x, bird_y, m_px, m_py, m_bx, m_by);
        end
    endtask

    // Observe a full 16-pixel sweep starting the cycle after entry, then done
    task automatic sweep_expect(input int bx0, input int by0, input logic [2:0] col, input string tag);
        for (int p = 0; p < 16; p++) begin
            tick;
            n_checks++;
            if (plot !== 1'b1 || x_out !== 8'(bx0 + p % 4) || y_out !== 7'(by0 + p / 4) ||
                colour !== col || done_drawing !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pixel %0d: got plot=%b x=%0d y=%0d col=%b done=%b want plot=1 x=%0d y=%0d col=%b done=0",
                         tag, p, plot, x_out, y_out, colour, done_drawing, bx0 + p % 4, by0 + p / 4, col);
            end
        end
        tick;
        n_checks++;
        if (plot !== 1'b0 || done_drawing !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: got plot=%b done=%b want plot=0 done=1", tag, plot, done_drawing);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        state   = CLR;
        porb    = 1'b0;
        model_reset();
        repeat (3) tick;
        n_checks++;
        if (plot !== 1'b0 || x_out !== 8'd0 || y_out !== 7'd0 || colour !== 3'd0 || done_drawing !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got plot=%b x=%0d y=%0d col=%b done=%b want all 0",
                     plot, x_out, y_out, colour, done_drawing);
        end
        check_positions("reset");
        reset_n = 1'b1;
        set_inputs(CLR, 1'b0);
        sweep_expect(78, 58, 3'b011, "reset_clear");
    endtask

    task automatic test_moves_draw;
        set_inputs(RGT, 1'b0); tick;
        set_inputs(UPS, 1'b0); tick;
        n_checks++;
        if (player_x !== 8'd79 || player_y !== 7'd57) begin
            n_fail++;
            $display("FAIL move_player: got (%0d,%0d) want (79,57)", player_x, player_y);
        end
        set_inputs(DRW, 1'b0);
        sweep_expect(m_px, m_py, 3'b111, "draw_player");
    endtask

    task automatic test_random_moves;
        logic [3:0] pool [6] = '{RGT, LFT, DWN, UPS, 4'd0, 4'd4};
        for (int i = 0; i < 300; i++) begin
            set_inputs(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            tick;
            check_positions("random_move");
        end
    endtask

    task automatic test_bird_edges;
        for (int i = 0; i < 170 && m_bx < XMAX; i++) begin
            set_inputs(RGT, 1'b1); tick;
            set_inputs(4'd0, 1'b1); tick;
        end
        for (int i = 0; i < 3; i++) begin
            set_inputs(RGT, 1'b1); tick;
            n_checks++;
            if (bird_x !== 8'd156) begin
                n_fail++;
                $display("FAIL bird_x_clamp: got %0d want 156", bird_x);
            end
            set_inputs(4'd0, 1'b1); tick;
        end
        for (int i = 0; i < 130 && m_by > 0; i++) begin
            set_inputs(UPS, 1'b1); tick;
            set_inputs(4'd0, 1'b1); tick;
        end
        for (int i = 0; i < 3; i++) begin
            set_inputs(UPS, 1'b1); tick;
            n_checks++;
            if (bird_y !== 7'd0) begin
                n_fail++;
                $display("FAIL bird_y_clamp: got %0d want 0", bird_y);
            end
            set_inputs(4'd0, 1'b1); tick;
        end
        check_positions("bird_edges");
    endtask

    task automatic test_clear_to_draw;
        set_inputs(4'd0, 1'b0); tick;
        set_inputs(CLR, 1'b0);
        sweep_expect(m_px, m_py, 3'b011, "clear_player");
        repeat (2) tick;
        n_checks++;
        if (plot !== 1'b0 || done_drawing !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_dwell: got plot=%b done=%b want plot=0 done=1", plot, done_drawing);
        end
        set_inputs(DRW, 1'b0);
        #1;
        n_checks++;
        if (done_drawing !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_done: got done=%b want 0", done_drawing);
        end
        sweep_expect(m_px, m_py, 3'b111, "draw_after_clear");
    endtask

    task automatic test_back_to_back;
        int ox, oy;
        set_inputs(4'd0, 1'b1); tick;
        set_inputs(DRW, 1'b1);
        for (int p = 0; p < 6; p++) begin
            tick;
            n_checks++;
            if (plot !== 1'b1 || colour !== 3'b100 || x_out !== 8'(m_bx + p % 4) || y_out !== 7'(m_by + p / 4)) begin
                n_fail++;
                $display("FAIL bird_draw pixel %0d: got plot=%b x=%0d y=%0d col=%b", p, plot, x_out, y_out, colour);
            end
        end
        set_inputs(CLR, 1'b0);
        sweep_expect(m_px, m_py, 3'b011, "restart_clear");
        // A move entry mid-sweep shifts the object but not the sweep base
        set_inputs(4'd0, 1'b0); tick;
        set_inputs(DWN, 1'b0); tick;
        set_inputs(DRW, 1'b0);
        ox = m_px; oy = m_py;
        for (int p = 0; p < 16; p++) begin
            if (p == 3) set_inputs(LFT, 1'b0);
            if (p == 8) set_inputs(UPS, 1'b0);
            tick;
            n_checks++;
            if (plot !== 1'b1 || x_out !== 8'(ox + p % 4) || y_out !== 7'(oy + p / 4) || colour !== 3'b111) begin
                n_fail++;
                $display("FAIL move_mid_sweep pixel %0d: got plot=%b x=%0d y=%0d col=%b want x=%0d y=%0d",
                         p, plot, x_out, y_out, colour, ox + p % 4, oy + p / 4);
            end
        end
        tick;
        n_checks++;
        if (plot !== 1'b0 || done_drawing !== 1'b0) begin
            n_fail++;
            $display("FAIL move_mid_sweep end: got plot=%b done=%b want plot=0 done=0", plot, done_drawing);
        end
        check_positions("move_mid_sweep");
    endtask

    task automatic test_reset_mid_sweep;
        set_inputs(4'd0, 1'b0); tick;
        set_inputs(DRW, 1'b0);
        repeat (8) tick;
        n_checks++;
        if (plot !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset pixel7: got plot=%b want 1", plot);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (plot !== 1'b0 || x_out !== 8'd0 || y_out !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: got plot=%b x=%0d y=%0d want 0 0 0", plot, x_out, y_out);
        end
        check_positions("reset_mid_sweep");
        state = 4'd0;
        repeat (2) tick;
        reset_n = 1'b1;
        set_inputs(4'd0, 1'b0);
        repeat (3) begin
            tick;
            n_checks++;
            if (plot !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset: got plot=%b want 0", plot);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_moves_draw();
        test_random_moves();
        test_bird_edges();
        test_clear_to_draw();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
